// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for the CPU memory port
//
// Purpose:
//   Grants one of two requesters (port 0 = instruction fetch, port 1 = load/store)
//   one transaction at a time, checks alignment against the access width, drives
//   the memory handshake with an ack timeout and returns a one-cycle completion
//   pulse with read data and an error flag.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pN_req/addr/data/we/
//     access_width                request and its fields (N = 0, 1)
//   pN_gnt                        one-cycle pulse: request captured
//   pN_done/rdata/err             one-cycle completion pulse with read data and error
//   mem_valid/addr/data/we/
//     access_width                latched request towards the memory controller
//   mem_ack, mem_rdata            memory completion and read data
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_data,
  input  logic        p0_we,
  input  logic [1:0]  p0_access_width,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_data,
  input  logic        p1_we,
  input  logic [1:0]  p1_access_width,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic [1:0]  mem_access_width,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // REJECT is the cycle an illegal request spends in place of BUSY, so that a
  // rejected request completes with the same latency as a one-cycle memory access
  // while mem_valid stays low.
  typedef enum logic [1:0] {IDLE, BUSY, REJECT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  width_q, width_d;

  logic        win;
  logic [31:0] win_addr;
  logic [31:0] win_data;
  logic        win_we;
  logic [1:0]  win_width;

  function automatic logic aligned(input logic [1:0] width, input logic [1:0] lsb);
    case (width)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lsb[0];
      2'b10:   aligned = (lsb == 2'b00);
      default: aligned = 1'b0;
    endcase
  endfunction

  // Keeps only the bytes covered by the access width, zero-filling the rest.
  function automatic logic [31:0] fit(input logic [1:0] width, input logic [31:0] value);
    case (width)
      2'b00:   fit = {24'b0, value[7:0]};
      2'b01:   fit = {16'b0, value[15:0]};
      default: fit = value;
    endcase
  endfunction

  // On a tie the port that was not served last wins.
  assign win       = (p0_req & p1_req) ? ~last_gnt_q : p1_req;
  assign win_addr  = win ? p1_addr : p0_addr;
  assign win_data  = win ? p1_data : p0_data;
  assign win_we    = win ? p1_we : p0_we;
  assign win_width = win ? p1_access_width : p0_access_width;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    err_d      = 2'b00;
    rdata_d[0] = '0;
    rdata_d[1] = '0;
    valid_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    width_d    = width_q;

    unique case (state_q)
      IDLE: begin
        if (p0_req | p1_req) begin
          sel_d        = win;
          gnt_d[win]   = 1'b1;
          addr_d       = win_addr;
          wdata_d      = fit(win_width, win_data);
          we_d         = win_we;
          width_d      = win_width;
          if (aligned(win_width, win_addr[1:0])) begin
            state_d = BUSY;
            valid_d = 1'b1;
          end else begin
            state_d = REJECT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack) begin
          state_d        = RESP;
          done_d[sel_q]  = 1'b1;
          rdata_d[sel_q] = we_q ? 32'b0 : fit(width_q, mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d       = RESP;
          done_d[sel_q] = 1'b1;
          err_d[sel_q]  = 1'b1;
        end else begin
          valid_d = 1'b1;
        end
      end
      REJECT: begin
        state_d       = RESP;
        done_d[sel_q] = 1'b1;
        err_d[sel_q]  = 1'b1;
      end
      RESP: begin
        last_gnt_d = sel_q;
        cnt_d      = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      width_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      width_q    <= width_d;
    end
  end

  assign p0_gnt           = gnt_q[0];
  assign p1_gnt           = gnt_q[1];
  assign p0_done          = done_q[0];
  assign p1_done          = done_q[1];
  assign p0_err           = err_q[0];
  assign p1_err           = err_q[1];
  assign p0_rdata         = rdata_q[0];
  assign p1_rdata         = rdata_q[1];
  assign mem_valid        = valid_q;
  assign mem_addr         = addr_q;
  assign mem_data         = wdata_q;
  assign mem_we           = we_q;
  assign mem_access_width = width_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] addr [2];
  logic [31:0] data [2];
  logic [1:0]  we;
  logic [1:0]  aw [2];
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_data;
  logic [1:0]  mem_access_width;

  logic [137:0] all_outs;
  assign all_outs = {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_valid, mem_we,
                     mem_access_width, p0_rdata, p1_rdata, mem_addr, mem_data};

  int total = 0;
  int bad = 0;
  int m_last = 1;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_data(data[0]), .p0_we(we[0]),
    .p0_access_width(aw[0]), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_data(data[1]), .p1_we(we[1]),
    .p1_access_width(aw[1]), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_access_width(mem_access_width), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes, alignment rule and width truncation.
  function automatic int size_of(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_legal(input logic [31:0] a, input logic [1:0] w);
    if (w == 2'd3) return 1'b0;
    return (a % size_of(w)) == 0;
  endfunction

  function automatic logic [31:0] trunc(input logic [31:0] d, input logic [1:0] w);
    longint unsigned m;
    m = (64'd1 << (8 * size_of(w))) - 1;
    return 32'(d & m);
  endfunction

  function automatic int pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction

  // Drives one transaction from an IDLE cycle and records what the DUT did.
  // ack_at is the 1-based BUSY cycle carrying mem_ack (0 = never).
  task automatic do_txn(input logic r0, input logic r1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic we0, input logic we1,
                        input logic [1:0] w0, input logic [1:0] w1,
                        input int ack_at, input logic [31:0] rdv,
                        output int g_port, output int g_cyc, output int d_port,
                        output int d_cyc, output int vcnt, output int side,
                        output logic [31:0] o_rdata, output logic o_err,
                        output logic [31:0] m_addr, output logic [31:0] m_data,
                        output logic m_we, output logic [1:0] m_w);
    g_port = -1; g_cyc = -1; d_port = -1; d_cyc = -1; vcnt = 0; side = 0;
    o_rdata = 'x; o_err = 1'bx; m_addr = 'x; m_data = 'x; m_we = 1'bx; m_w = 'x;
    req = {r1, r0};
    addr[0] = a0; addr[1] = a1; data[0] = d0; data[1] = d1;
    we = {we1, we0}; aw[0] = w0; aw[1] = w1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (p0_gnt && p1_gnt) side++;
      if (p0_gnt || p1_gnt) begin
        if (g_port < 0) begin g_port = p1_gnt ? 1 : 0; g_cyc = c; end
        else side++;
        req = 2'b00;
      end
      if (mem_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          m_addr = mem_addr; m_data = mem_data; m_we = mem_we; m_w = mem_access_width;
        end
        if (vcnt == ack_at) begin mem_ack = 1'b1; mem_rdata = rdv; end
      end
      if (p0_done || p1_done) begin
        if (p0_done && p1_done) side++;
        d_port = p1_done ? 1 : 0;
        d_cyc = c;
        o_rdata = p1_done ? p1_rdata : p0_rdata;
        o_err = p1_done ? p1_err : p0_err;
        if (d_port == 0 && (p1_rdata != 0 || p1_err)) side++;
        if (d_port == 1 && (p0_rdata != 0 || p0_err)) side++;
        break;
      end
    end
    req = 2'b00;
    mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; mem_ack = 1'b0; mem_rdata = '0;
    addr[0] = 0; addr[1] = 0; data[0] = 0; data[1] = 0; we = 0; aw[0] = 2; aw[1] = 2;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
    req = 2'b00;
    rst = 1'b0;
    m_last = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int gp, gc, dp, dc, vc, sd; logic [31:0] rd, ma, md; logic er, mw; logic [1:0] mwd;
    do_txn(1, 0, 32'h100, 0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 32'hDEADBEEF,
           gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
    total++; if (gp !== 0 || gc !== 1) begin bad++; $display("FAIL single_gnt got=%0d@%0d want=0@1", gp, gc); end
    total++; if (vc !== 1) begin bad++; $display("FAIL single_valid_cycles got=%0d want=1", vc); end
    total++; if (dp !== 0 || dc !== 2) begin bad++; $display("FAIL single_done got=%0d@%0d want=0@2", dp, dc); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL single_rdata got=%h/%b want=deadbeef/0", rd, er); end
    total++; if (ma !== 32'h100 || mw !== 1'b0 || mwd !== 2'd2) begin bad++; $display("FAIL single_mem_fields got=%h/%b/%0d", ma, mw, mwd); end
    m_last = 0;
  endtask

  task automatic test_masked_write_read();
    int gp, gc, dp, dc, vc, sd; logic [31:0] rd, ma, md; logic er, mw; logic [1:0] mwd;
    do_txn(0, 1, 0, 32'h203, 0, 32'h12345678, 0, 1, 2'd0, 2'd0, 1, 32'hFFFFFFFF,
           gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
    total++; if (md !== 32'h00000078 || mw !== 1'b1) begin bad++; $display("FAIL byte_write_data got=%h we=%b want=00000078 we=1", md, mw); end
    total++; if (dp !== 1 || rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL byte_write_done got=p%0d %h/%b want=p1 0/0", dp, rd, er); end
    m_last = 1;
    do_txn(0, 1, 0, 32'h202, 0, 32'h0, 0, 0, 2'd0, 2'd1, 1, 32'hAAAABBBB,
           gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
    total++; if (dp !== 1 || rd !== 32'h0000BBBB || er !== 1'b0) begin bad++; $display("FAIL half_read got=p%0d %h/%b want=p1 0000bbbb/0", dp, rd, er); end
    total++; if (sd !== 0) begin bad++; $display("FAIL half_read_side got=%0d want=0", sd); end
    m_last = 1;
  endtask

  task automatic test_round_robin();
    int ports[$]; int cycs[$]; int first; int n0;
    first = 1 - m_last;
    req = 2'b11;
    addr[0] = 32'h40; addr[1] = 32'h80; data[0] = 1; data[1] = 2;
    we = 2'b00; aw[0] = 2'd2; aw[1] = 2'd2;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      mem_ack = mem_valid;
      mem_rdata = $urandom;
      if (p0_gnt || p1_gnt) begin
        ports.push_back(p1_gnt ? 1 : 0);
        cycs.push_back(c);
        if (ports.size() == 10) begin req = 2'b00; break; end
      end
    end
    @(posedge clk); #1; mem_ack = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ports.size() != 10) begin bad++; $display("FAIL rr_count got=%0d want=10", ports.size()); end
    else begin
      n0 = 0;
      for (int i = 0; i < 10; i++) begin
        total++;
        if (ports[i] != (first + i) % 2 || cycs[i] != 1 + 3 * i) begin
          bad++; $display("FAIL rr_grant_%0d got=p%0d@%0d want=p%0d@%0d", i, ports[i], cycs[i], (first + i) % 2, 1 + 3 * i);
        end
        if (ports[i] == 0) n0++;
      end
      total++; if (n0 != 5) begin bad++; $display("FAIL rr_fairness got=%0d want=5", n0); end
    end
    m_last = (first + 9) % 2;
  endtask

  task automatic test_illegal();
    int gp, gc, dp, dc, vc, sd; logic [31:0] rd, ma, md; logic er, mw; logic [1:0] mwd;
    logic [31:0] ca [3]; logic [1:0] cw [3]; int cp [3];
    ca[0] = 32'h102; cw[0] = 2'd2; cp[0] = 1;
    ca[1] = 32'h001; cw[1] = 2'd1; cp[1] = 0;
    ca[2] = 32'h000; cw[2] = 2'd3; cp[2] = 1;
    for (int i = 0; i < 3; i++) begin
      do_txn(cp[i] == 0, cp[i] == 1, ca[i], ca[i], 32'h55, 32'h55, 0, 0, cw[i], cw[i], 1, 32'h1,
             gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
      total++;
      if (gp !== cp[i] || dp !== cp[i] || dc !== 2 || er !== 1'b1 || rd !== 0 || vc !== 0) begin
        bad++; $display("FAIL illegal_%0d got=g%0d d%0d@%0d err=%b rd=%h valid=%0d want=g%0d d%0d@2 err=1 rd=0 valid=0",
                        i, gp, dp, dc, er, rd, vc, cp[i], cp[i]);
      end
      m_last = cp[i];
    end
  endtask

  task automatic test_timeout();
    int gp, gc, dp, dc, vc, sd; logic [31:0] rd, ma, md; logic er, mw; logic [1:0] mwd;
    do_txn(1, 0, 32'h10, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 32'h0,
           gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
    total++; if (vc !== TMO || dc !== TMO + 1 || er !== 1'b1 || rd !== 0) begin
      bad++; $display("FAIL timeout got=valid%0d done@%0d err=%b rd=%h want=valid%0d done@%0d err=1 rd=0", vc, dc, er, rd, TMO, TMO + 1);
    end
    m_last = 0;
    do_txn(1, 0, 32'h10, 0, 0, 0, 0, 0, 2'd2, 2'd0, TMO, 32'hCAFEF00D,
           gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
    total++; if (vc !== TMO || dc !== TMO + 1 || er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL late_ack got=valid%0d done@%0d err=%b rd=%h want=valid%0d done@%0d err=0 rd=cafef00d", vc, dc, er, rd, TMO, TMO + 1);
    end
    m_last = 0;
  endtask

  task automatic test_reset_mid_busy();
    int gp, gc, dp, dc, vc, sd; logic [31:0] rd, ma, md; logic er, mw; logic [1:0] mwd;
    int seen_done;
    // Leave port 0 as the last served so a post-reset tie going to p0 shows the reset.
    do_txn(1, 0, 32'h20, 0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 32'h7,
           gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
    req = 2'b10; addr[1] = 32'h300; we = 2'b10; data[1] = 32'hFFFF; aw[1] = 2'd2;
    @(posedge clk); #1;
    req = 2'b00;
    @(posedge clk); #1;
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL mid_busy_valid got=%b want=1", mem_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (all_outs !== '0) begin bad++; $display("FAIL mid_reset_outputs got=%h want=0", all_outs); end
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (p0_done || p1_done || mem_valid) seen_done++;
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL mid_reset_quiet got=%0d want=0", seen_done); end
    m_last = 1;
    do_txn(1, 1, 32'h44, 32'h48, 0, 0, 0, 0, 2'd2, 2'd2, 1, 32'h9,
           gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
    total++; if (gp !== 0 || dp !== 0 || ma !== 32'h44) begin bad++; $display("FAIL post_reset_tie got=g%0d d%0d addr=%h want=g0 d0 addr=44", gp, dp, ma); end
    m_last = 0;
  endtask

  task automatic test_random();
    int gp, gc, dp, dc, vc, sd; logic [31:0] rd, ma, md; logic er, mw; logic [1:0] mwd;
    logic r0, r1; logic [31:0] a [2]; logic [31:0] d [2]; logic [1:0] w [2]; logic [1:0] wr;
    int ack_at, win, e_vc, e_dc; logic [31:0] rdv, e_rd; logic e_er; bit ok;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: begin r0 = 1; r1 = 0; end
        1: begin r0 = 0; r1 = 1; end
        default: begin r0 = 1; r1 = 1; end
      endcase
      for (int p = 0; p < 2; p++) begin
        a[p] = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
        d[p] = $urandom;
        w[p] = 2'($urandom_range(0, 3));
      end
      wr = 2'($urandom_range(0, 3));
      ack_at = $urandom_range(0, TMO + 1);
      rdv = $urandom;
      win = pick(r0, r1, m_last);
      if (!is_legal(a[win], w[win])) begin
        e_vc = 0; e_dc = 2; e_er = 1'b1; e_rd = 0;
      end else begin
        ok = (ack_at >= 1 && ack_at <= TMO);
        e_vc = ok ? ack_at : TMO;
        e_dc = e_vc + 1;
        e_er = !ok;
        e_rd = (ok && !wr[win]) ? trunc(rdv, w[win]) : 32'h0;
      end
      do_txn(r0, r1, a[0], a[1], d[0], d[1], wr[0], wr[1], w[0], w[1], ack_at, rdv,
             gp, gc, dp, dc, vc, sd, rd, er, ma, md, mw, mwd);
      total++;
      if (gp !== win || gc !== 1 || dp !== win || dc !== e_dc || vc !== e_vc || sd !== 0) begin
        bad++; $display("FAIL rnd%0d_flow got=g%0d@%0d d%0d@%0d v%0d s%0d want=g%0d@1 d%0d@%0d v%0d s0",
                        t, gp, gc, dp, dc, vc, sd, win, win, e_dc, e_vc);
      end
      total++;
      if (rd !== e_rd || er !== e_er) begin
        bad++; $display("FAIL rnd%0d_resp got=%h/%b want=%h/%b", t, rd, er, e_rd, e_er);
      end
      if (e_vc > 0) begin
        total++;
        if (ma !== a[win] || md !== trunc(d[win], w[win]) || mw !== wr[win] || mwd !== w[win]) begin
          bad++; $display("FAIL rnd%0d_mem got=%h/%h/%b/%0d want=%h/%h/%b/%0d", t, ma, md, mw, mwd,
                          a[win], trunc(d[win], w[win]), wr[win], w[win]);
        end
      end
      m_last = win;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_masked_write_read();
    test_round_robin();
    test_illegal();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
